ram_arbiter: RTL and testbench

- Downstream of coherence control. Merges instruction and data requests from both cores' caches onto the single RAM port.
- Data requests take priority over instruction requests. Cores are chosen round-robin, with separate pointers for data and instruction.
- Holds a data grant for a whole multi-word block transfer.
- Services cache-to-cache transfers flagged by coherence control by writing the supplier's word back to RAM and forwarding it to the requester.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/rr_picker.sv | 16 +
 rtl/ram_arbiter.sv | 141 ++++++++++++++
 tb/tb_ram_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word, RAM state and arbiter state types
package cpu_types_pkg;

    localparam int WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Visible to coherence control so it can tell which cache owns the RAM port
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - two-way round-robin winner select
module rr_picker (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       win_o
);

    // The pointed-at core wins if it is asking, otherwise the other core does
    always_comb begin
        win_o = ptr_i;
        if (!req_i[ptr_i]) begin
            win_o = ~ptr_i;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - merges both cores' I/D cache requests onto one RAM port
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int WORD_W = WORD_BITS
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        c2c,
    input  logic [CPUS-1:0]             iREN,
    input  logic [CPUS-1:0][WORD_W-1:0] iaddr,
    output logic [CPUS-1:0]             iwait,
    output logic [CPUS-1:0][WORD_W-1:0] iload,
    input  logic [CPUS-1:0]             dREN,
    input  logic [CPUS-1:0]             dWEN,
    input  logic [CPUS-1:0][WORD_W-1:0] daddr,
    input  logic [CPUS-1:0][WORD_W-1:0] dstore,
    output logic [CPUS-1:0]             dwait,
    output logic [CPUS-1:0][WORD_W-1:0] dload,
    output logic                        ramREN,
    output logic                        ramWEN,
    output logic [WORD_W-1:0]           ramaddr,
    output logic [WORD_W-1:0]           ramstore,
    input  logic [WORD_W-1:0]           ramload,
    input  ramstate_t                   ramstate
);

    arb_state_t      state_q, state_d;
    logic            gnt_q, gnt_d;
    logic            drp_q, drp_d;
    logic            irp_q, irp_d;
    logic [CPUS-1:0] dreq;
    logic            dwin, iwin;
    logic            other;
    logic            access;

    assign dreq   = dREN | dWEN;
    assign other  = ~gnt_q;
    assign access = (ramstate == ACCESS);

    rr_picker u_dpick (
        .req_i (dreq),
        .ptr_i (drp_q),
        .win_o (dwin)
    );

    rr_picker u_ipick (
        .req_i (iREN),
        .ptr_i (irp_q),
        .win_o (iwin)
    );

    // Grant state and round-robin pointers; reset clears them so RAM enables drop at once
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            drp_q   <= 1'b0;
            irp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            drp_q   <= drp_d;
            irp_q   <= irp_d;
        end
    end

    // Next grant and RAM/cache steering, all decoded from the registered grant
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        drp_d    = drp_q;
        irp_d    = irp_q;
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        unique case (state_q)
            IDLE: begin
                if (|dreq) begin
                    state_d = DGRANT;
                    gnt_d   = dwin;
                end else if (|iREN) begin
                    state_d = IGRANT;
                    gnt_d   = iwin;
                end
            end
            DGRANT: begin
                if (dWEN[gnt_q]) begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[gnt_q];
                    ramstore = dstore[gnt_q];
                    if (access) begin
                        dwait[gnt_q] = 1'b0;
                    end
                end else if (dREN[gnt_q]) begin
                    ramaddr = daddr[gnt_q];
                    if (c2c) begin
                        // Supplier's word goes to RAM and straight to the requester
                        ramWEN   = 1'b1;
                        ramstore = dstore[other];
                        if (access) begin
                            dwait[gnt_q] = 1'b0;
                            dload[gnt_q] = dstore[other];
                        end
                    end else begin
                        ramREN = 1'b1;
                        if (access) begin
                            dwait[gnt_q] = 1'b0;
                            dload[gnt_q] = ramload;
                        end
                    end
                end else begin
                    state_d = IDLE;
                    drp_d   = other;
                end
            end
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[gnt_q];
                if (access) begin
                    iwait[gnt_q] = 1'b0;
                    iload[gnt_q] = ramload;
                    state_d      = IDLE;
                    irp_d        = other;
                end else if (!iREN[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a RAM model
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam logic [1:0] K_RD  = 2'd0;
    localparam logic [1:0] K_WR  = 2'd1;
    localparam logic [1:0] K_C2C = 2'd2;
    localparam logic [1:0] K_RW  = 2'd3;
    localparam int WAIT_MAX = 3000;

    typedef struct packed {
        logic [1:0] kind;
        word_t      addr;
        word_t      data;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RST;
    logic             c2c;
    logic [1:0]       iREN, dREN, dWEN, iwait, dwait;
    logic [1:0][31:0] iaddr, daddr, dstore, iload, dload;
    logic             ramREN, ramWEN;
    word_t            ramaddr, ramstore, ramload;
    ramstate_t        ramstate;

    logic  tb_iren [2];
    logic  tb_dren [2];
    logic  tb_dwen [2];
    word_t tb_iaddr [2];
    word_t tb_daddr [2];
    word_t tb_dstore [2];

    assign iREN   = {tb_iren[1], tb_iren[0]};
    assign dREN   = {tb_dren[1], tb_dren[0]};
    assign dWEN   = {tb_dwen[1], tb_dwen[0]};
    assign iaddr  = {tb_iaddr[1], tb_iaddr[0]};
    assign daddr  = {tb_daddr[1], tb_daddr[0]};
    assign dstore = {tb_dstore[1], tb_dstore[0]};

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    fixed_lat = -1;
    bit    hold_busy = 1'b0;
    bit    check_loads = 1'b0;
    int    busy_left = -1;
    int    i_cyc [2] = '{0, 0};
    int    d_cyc [2] = '{0, 0};
    int    d_prev [2] = '{0, 0};
    int    d_cnt [2] = '{0, 0};
    word_t ram_mem [word_t];
    word_t ref_mem [word_t];
    exp_t  iq [2][$];
    exp_t  dq [2][$];

    ram_arbiter #(.CPUS(2), .WORD_W(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .c2c      (c2c),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic word_t ifn(input word_t a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic word_t ram_rd(input word_t a);
        return ram_mem.exists(a) ? ram_mem[a] : ifn(a);
    endfunction

    function automatic word_t ref_rd(input word_t a);
        return ref_mem.exists(a) ? ref_mem[a] : ifn(a);
    endfunction

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ifetch(input int c, input word_t a, input word_t exp_data);
        exp_t e;
        int   n;
        n      = 0;
        e.kind = K_RD;
        e.addr = a;
        e.data = exp_data;
        iq[c].push_back(e);
        tb_iaddr[c] = a;
        tb_iren[c]  = 1'b1;
        forever begin
            @(negedge CLK);
            if (!iwait[c]) break;
            n++;
            if (n > WAIT_MAX) begin
                chk("ifetch_timeout", 32'(iwait[c]), 32'd0);
                break;
            end
        end
        tick();
        tb_iren[c] = 1'b0;
    endtask

    task automatic dxfer(input int c, input logic [1:0] kind, input word_t a0,
                         input int words, input word_t wd);
        exp_t  e;
        word_t a, v;
        int    n;
        for (int w = 0; w < words; w++) begin
            a = a0 + 32'(4 * w);
            v = wd + 32'(w);
            tb_daddr[c] = a;
            e.addr = a;
            case (kind)
                K_RD: begin
                    tb_dren[c] = 1'b1; tb_dwen[c] = 1'b0;
                    e.kind = K_RD; e.data = ref_rd(a);
                end
                K_WR: begin
                    tb_dren[c] = 1'b0; tb_dwen[c] = 1'b1; tb_dstore[c] = v;
                    e.kind = K_WR; e.data = v; ref_mem[a] = v;
                end
                K_RW: begin
                    tb_dren[c] = 1'b1; tb_dwen[c] = 1'b1; tb_dstore[c] = v;
                    e.kind = K_WR; e.data = v; ref_mem[a] = v;
                end
                default: begin
                    tb_dren[c] = 1'b1; tb_dwen[c] = 1'b0; c2c = 1'b1; tb_dstore[1-c] = v;
                    e.kind = K_C2C; e.data = v; ref_mem[a] = v;
                end
            endcase
            dq[c].push_back(e);
            n = 0;
            forever begin
                @(negedge CLK);
                if (!dwait[c]) break;
                n++;
                if (n > WAIT_MAX) begin
                    chk("dxfer_timeout", 32'(dwait[c]), 32'd0);
                    break;
                end
            end
            tick();
        end
        tb_dren[c] = 1'b0;
        tb_dwen[c] = 1'b0;
        c2c        = 1'b0;
    endtask

    task automatic data_proc(input int c);
        logic [1:0] k;
        word_t      base;
        base = 32'(32'h1000 * (c + 1));
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 2))
                0:       k = K_RD;
                1:       k = K_WR;
                default: k = K_RW;
            endcase
            dxfer(c, k, base + 32'($urandom_range(0, 15) * 4), int'($urandom_range(1, 3)), $urandom);
            repeat ($urandom_range(1, 6)) tick();
        end
    endtask

    task automatic inst_proc(input int c);
        word_t a;
        for (int n = 0; n < 30; n++) begin
            a = 32'h8000 + 32'($urandom_range(0, 63) * 4);
            ifetch(c, a, ifn(a));
            repeat ($urandom_range(0, 5)) tick();
        end
    endtask

    // RAM: random or fixed BUSY count before ACCESS on any enabled cycle
    initial begin
        ramstate = FREE;
        ramload  = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (RST || !(ramREN || ramWEN)) begin
                ramstate  = FREE;
                ramload   = $urandom;
                busy_left = -1;
            end else begin
                if (busy_left < 0) busy_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                if (hold_busy || busy_left > 0) begin
                    ramstate = BUSY;
                    ramload  = $urandom;
                    if (!hold_busy) busy_left--;
                end else begin
                    ramstate  = ACCESS;
                    busy_left = -1;
                    if (ramWEN) begin
                        ram_mem[ramaddr] = ramstore;
                        ramload = $urandom;
                    end else begin
                        ramload = ram_rd(ramaddr);
                    end
                end
            end
        end
    end

    task automatic mon_cycle();
        exp_t e;
        int   lows;
        bit   acc;
        lows = 0;
        acc  = (ramstate == ACCESS) && (ramREN || ramWEN);
        for (int c = 0; c < 2; c++) lows += (iwait[c] ? 0 : 1) + (dwait[c] ? 0 : 1);
        if (acc || lows != 0) chk("wait_pulse_count", 32'(lows), acc ? 32'd1 : 32'd0);
        for (int c = 0; c < 2; c++) begin
            if (!iwait[c]) begin
                chk("i_pulse_expected", 32'(iq[c].size() != 0), 32'd1);
                if (iq[c].size() != 0) begin
                    e = iq[c].pop_front();
                    i_cyc[c] = cyc;
                    chk("i_ram_en", 32'({ramWEN, ramREN}), 32'd1);
                    chk("i_addr", ramaddr, e.addr);
                    chk("i_load", iload[c], e.data);
                end
            end
            if (!dwait[c]) begin
                chk("d_pulse_expected", 32'(dq[c].size() != 0), 32'd1);
                if (dq[c].size() != 0) begin
                    e = dq[c].pop_front();
                    d_prev[c] = d_cyc[c];
                    d_cyc[c]  = cyc;
                    d_cnt[c]++;
                    chk("d_addr", ramaddr, e.addr);
                    if (e.kind == K_RD) begin
                        chk("d_rd_en", 32'({ramWEN, ramREN}), 32'd1);
                        chk("d_rd_load", dload[c], e.data);
                    end else begin
                        chk("d_wr_en", 32'({ramWEN, ramREN}), 32'd2);
                        chk("d_store", ramstore, e.data);
                        chk("d_wr_load", dload[c], (e.kind == K_C2C) ? e.data : 32'd0);
                    end
                end
            end
            if (check_loads) begin
                if (iwait[c]) chk("i_idle_load", iload[c], 32'd0);
                if (dwait[c]) chk("d_idle_load", dload[c], 32'd0);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) mon_cycle();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, base, n;
        RST = 1'b1;
        c2c = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tb_iren[c] = 1'b0; tb_dren[c] = 1'b0; tb_dwen[c] = 1'b0;
            tb_iaddr[c] = '0; tb_daddr[c] = '0; tb_dstore[c] = '0;
        end
        repeat (3) @(negedge CLK);
        chk("rst_iwait", 32'(iwait), 32'd3);
        chk("rst_dwait", 32'(dwait), 32'd3);
        chk("rst_ram_en", 32'({ramWEN, ramREN}), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_iload", iload[0] | iload[1], 32'd0);
        chk("rst_dload", dload[0] | dload[1], 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        tick();
        RST = 1'b0;

        // reset in the middle of a held data write
        hold_busy = 1'b1;
        tb_daddr[0] = 32'h40; tb_dstore[0] = 32'h11; tb_dwen[0] = 1'b1;
        n = 0;
        forever begin
            @(negedge CLK);
            n++;
            if (ramWEN || n > 20) break;
        end
        chk("t1_wen_before_reset", 32'(ramWEN), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("t1_rst_wen", 32'(ramWEN), 32'd0);
        chk("t1_rst_ren", 32'(ramREN), 32'd0);
        chk("t1_rst_dwait", 32'(dwait), 32'd3);
        tb_dwen[0] = 1'b0;
        hold_busy  = 1'b0;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("t1_state_idle", 32'(dut.state_q), 32'(IDLE));

        // two instruction fetches, two BUSY cycles each
        fixed_lat = 2;
        ram_mem[32'h9000] = 32'hDEAD0000;
        tick();
        t0 = cyc;
        fork
            ifetch(0, 32'h9000, 32'hDEAD0000);
            ifetch(1, 32'h9004, ifn(32'h9004));
        join
        chk("t2_latency", 32'(i_cyc[0] - t0), 32'd3);
        chk("t2_core1_after_core0", 32'(i_cyc[1] > i_cyc[0]), 32'd1);

        // data beats instruction raised in the same cycle
        fixed_lat = 1;
        repeat (3) tick();
        fork
            ifetch(1, 32'h8010, ifn(32'h8010));
            dxfer(0, K_RD, 32'h1000, 1, 32'd0);
        join
        chk("t3_data_first", 32'(i_cyc[1] > d_cyc[0]), 32'd1);

        // two-word block keeps the grant, then pointer moves to core1
        repeat (3) tick();
        base = d_cnt[0];
        dxfer(0, K_RD, 32'h100, 2, 32'd0);
        chk("t4_pulses", 32'(d_cnt[0] - base), 32'd2);
        chk("t4_word_gap", 32'(d_cyc[0] - d_prev[0]), 32'd2);
        repeat (3) tick();
        fork
            dxfer(0, K_RD, 32'h108, 1, 32'd0);
            dxfer(1, K_RD, 32'h2000, 1, 32'd0);
        join
        chk("t4_drp_rotated", 32'(d_cyc[1] < d_cyc[0]), 32'd1);

        // cache-to-cache and simultaneous read+write
        repeat (3) tick();
        dxfer(0, K_C2C, 32'h200, 1, 32'hCAFEF00D);
        repeat (3) tick();
        dxfer(0, K_RW, 32'h300, 1, 32'h55);

        // randomized mixed traffic from both cores
        repeat (3) tick();
        fixed_lat   = -1;
        check_loads = 1'b1;
        fork
            data_proc(0);
            data_proc(1);
            inst_proc(0);
            inst_proc(1);
        join
        repeat (5) tick();

        for (int c = 0; c < 2; c++) begin
            chk("iq_drained", 32'(iq[c].size()), 32'd0);
            chk("dq_drained", 32'(dq[c].size()), 32'd0);
        end
        foreach (ref_mem[a]) chk("mem_image", ram_rd(a), ref_mem[a]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
